// File: rtl/semaforo_controlador_if.sv
// semaforo_controlador_if: control/status bundle of the vehicle-light sequencer
//   ENB        enable; 0 freezes the sequencer
//   Solicitud  pedestrian request (level or single-cycle pulse)
//   SemaforoA  approach A colour (0 red, 1 yellow, 2 green)
//   SemaforoB  approach B colour, same encoding
//   Cambio     one-cycle pulse after every phase transition
// master: the sequencer itself; slave: whoever drives ENB/Solicitud and consumes the colours.
interface semaforo_controlador_if;
    logic       ENB;
    logic       Solicitud;
    logic [1:0] SemaforoA;
    logic [1:0] SemaforoB;
    logic       Cambio;
    modport master (input ENB, Solicitud, output SemaforoA, SemaforoB, Cambio);
    modport slave (output ENB, Solicitud, input SemaforoA, SemaforoB, Cambio);
endinterface

// File: rtl/semaforo_controlador.sv
// semaforo_controlador: fixed-time six-phase two-approach vehicle-light sequencer
//   clk  rising-edge system clock
//   RST  asynchronous active-low reset
//   bus  semaforo_controlador_if.master: ENB, Solicitud in; SemaforoA, SemaforoB, Cambio out
// Green phases end early once a pedestrian request is pending and the minimum green has elapsed.
module semaforo_controlador #(
    parameter int unsigned T_VERDE     = 10,
    parameter int unsigned T_VERDE_MIN = 4,
    parameter int unsigned T_AMARILLO  = 3,
    parameter int unsigned T_ROJO      = 2,
    parameter int unsigned ANCHO       = 8
) (
    input logic                    clk,
    input logic                    RST,
    semaforo_controlador_if.master bus
);
    typedef enum logic [2:0] {
        ROJO_AB    = 3'd0,
        A_VERDE    = 3'd1,
        A_AMARILLO = 3'd2,
        ROJO_BA    = 3'd3,
        B_VERDE    = 3'd4,
        B_AMARILLO = 3'd5
    } fase_t;

    localparam logic [ANCHO-1:0] VERDE_FIN    = ANCHO'(T_VERDE - 1);
    localparam logic [ANCHO-1:0] VERDE_MIN    = ANCHO'(T_VERDE_MIN - 1);
    localparam logic [ANCHO-1:0] AMARILLO_FIN = ANCHO'(T_AMARILLO - 1);
    localparam logic [ANCHO-1:0] ROJO_FIN     = ANCHO'(T_ROJO - 1);
    localparam logic [ANCHO-1:0] UNO          = ANCHO'(1);

    fase_t            fase_q, fase_d, sig;
    logic [ANCHO-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic [1:0]       sem_a_q, sem_a_d, sem_b_q, sem_b_d;
    logic             cambio_q, cambio_d;
    logic             pend, verde_fin, fin, ilegal, avanza;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            fase_q   <= ROJO_AB;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            sem_a_q  <= 2'd0;
            sem_b_q  <= 2'd0;
            cambio_q <= 1'b0;
        end else begin
            fase_q   <= fase_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            sem_a_q  <= sem_a_d;
            sem_b_q  <= sem_b_d;
            cambio_q <= cambio_d;
        end
    end

    always_comb begin
        pend      = req_q | bus.Solicitud;
        verde_fin = (cnt_q == VERDE_FIN) | (pend & (cnt_q >= VERDE_MIN));
        ilegal    = 1'b0;
        case (fase_q)
            ROJO_AB:    begin fin = cnt_q == ROJO_FIN;     sig = A_VERDE;    end
            A_VERDE:    begin fin = verde_fin;             sig = A_AMARILLO; end
            A_AMARILLO: begin fin = cnt_q == AMARILLO_FIN; sig = ROJO_BA;    end
            ROJO_BA:    begin fin = cnt_q == ROJO_FIN;     sig = B_VERDE;    end
            B_VERDE:    begin fin = verde_fin;             sig = B_AMARILLO; end
            B_AMARILLO: begin fin = cnt_q == AMARILLO_FIN; sig = ROJO_AB;    end
            default:    begin fin = 1'b1; sig = ROJO_AB; ilegal = 1'b1;    end
        endcase
        // Unused encodings recover even while frozen.
        avanza = ilegal | (bus.ENB & fin);
        fase_d = avanza ? sig : fase_q;
        cnt_d  = avanza ? '0 : (bus.ENB ? cnt_q + UNO : cnt_q);
        // A request arriving on the edge that enters all-red survives the clear.
        req_d  = bus.Solicitud | (req_q & ~(avanza & (sig == ROJO_AB || sig == ROJO_BA)));
    end

    // Colours are decoded from the next phase so the registered outputs track fase_q exactly.
    always_comb begin
        sem_a_d  = 2'd0;
        sem_b_d  = 2'd0;
        case (fase_d)
            A_VERDE:    sem_a_d = 2'd2;
            A_AMARILLO: sem_a_d = 2'd1;
            B_VERDE:    sem_b_d = 2'd2;
            B_AMARILLO: sem_b_d = 2'd1;
            default:    sem_a_d = 2'd0;
        endcase
        cambio_d = bus.ENB & avanza;
    end

    assign bus.SemaforoA = sem_a_q;
    assign bus.SemaforoB = sem_b_q;
    assign bus.Cambio    = cambio_q;
endmodule

// File: doc/semaforo_controlador.md
# semaforo_controlador

Vehicle-light sequencer for the two-approach intersection. It generates the `SemaforoA`/`SemaforoB` colour codes consumed by the pedestrian-light stage directly downstream. It runs a fixed-time six-phase cycle with all-red clearance intervals, supports a pause via `ENB`, and shortens the active green when a pedestrian request is pending.

## Interface
- `T_VERDE`, 10: green duration in clock cycles (≥1)
- `T_VERDE_MIN`, 4: minimum green before a pedestrian request may end it (1 ≤ `T_VERDE_MIN` ≤ `T_VERDE`)
- `T_AMARILLO`, 3: yellow duration in cycles (≥1)
- `T_ROJO`, 2: all-red clearance duration in cycles (≥1)
- `ANCHO`, 8: phase-counter width; all durations must be ≤ 2^`ANCHO`
- `clk`  input  1  system clock, rising-edge
- `RST`  input  1  asynchronous, active-low reset
- `ENB`  input  1  enable; 0 freezes phase and counter
- `Solicitud`  input  1  pedestrian request, level or single-cycle pulse
- `SemaforoA`  output  2  approach A colour: 0 = red, 1 = yellow, 2 = green; 3 is never driven
- `SemaforoB`  output  2  approach B colour, same encoding
- `Cambio`  output  1  one-cycle pulse on every phase transition

## Operation
- Phase FSM: `ROJO_AB` → `A_VERDE` → `A_AMARILLO` → `ROJO_BA` → `B_VERDE` → `B_AMARILLO` → `ROJO_AB`.
- Outputs by phase (A/B):
  - `ROJO_AB` and `ROJO_BA`: 0/0
  - `A_VERDE`: 2/0
  - `A_AMARILLO`: 1/0
  - `B_VERDE`: 0/2
  - `B_AMARILLO`: 0/1
- Both approaches are never green or yellow at the same time, under any input sequence.
- Phase counter `cnt`:
  - Cleared on every transition.
  - Increments on each enabled edge that does not cause a transition.
- Transition conditions, evaluated on enabled edges:
  - Yellow and all-red phases leave when `cnt == T-1` for their duration `T`.
  - Green phases leave when `cnt == T_VERDE-1`, or when `pend` is set and `cnt >= T_VERDE_MIN-1`.
- Pending request `pend`:
  - `pend = req_q | Solicitud`.
  - `req_q` is set on any clock edge with `Solicitud=1`, regardless of `ENB`.
  - `req_q` is cleared on the edge that enters `ROJO_AB` or `ROJO_BA`. If `Solicitud=1` on that same edge, set wins.
- `ENB=0`:
  - Phase, `cnt`, `SemaforoA` and `SemaforoB` hold.
  - `Cambio` is 0.
  - Only `req_q` may change.
- Reset (`RST=0`, asynchronous, including mid-cycle):
  - Phase = `ROJO_AB`, `cnt = 0`, `req_q = 0`.
  - `SemaforoA = 0`, `SemaforoB = 0`, `Cambio = 0`.
- Illegal or unused state encodings recover to `ROJO_AB` on the next edge.

## Timing
- All outputs are registered and update on the same edge as the phase register; no combinational path from inputs to outputs.
- `Cambio` is 1 for exactly the cycle following a transition edge.
- With defaults and `ENB=1` throughout, the cycle period is 2+10+3+2+10+3 = 30 cycles.
- The first rising edge after `RST` deasserts counts as `ROJO_AB` `cnt = 0`, so A turns green after the 2nd enabled edge.
- Each phase lasts exactly its duration in enabled cycles; frozen cycles extend it one-for-one.
- Early termination: green ends on the edge where the condition first holds, and yellow appears in the following cycle.
- `Solicitud` during yellow or all-red is held in `req_q` only if it arrives after the clearing edge. It then shortens the next green to `T_VERDE_MIN` cycles.

## Test plan
- **Reset:** hold `RST=0` 3 cycles with `ENB=1` → A=0, B=0, `Cambio=0`. Assert `RST=0` asynchronously mid `B_VERDE` → outputs 0/0 immediately, before the next edge.
- **Free run:** release reset, `ENB=1`, `Solicitud=0` → A=2 for 10 cycles, A=1 for 3, 0/0 for 2, B=2 for 10, B=1 for 3, 0/0 for 2; `Cambio` pulses 6 times per 30 cycles. Check that A and B are never both non-red.
- **Freeze:** `ENB=0` for 5 cycles at `A_VERDE` `cnt = 3` → A=2 for 15 total cycles. Check that no `Cambio` occurs during the freeze.
- **Request after minimum:** 1-cycle `Solicitud` at `A_VERDE` `cnt = 6` → A=1 in the next cycle, so green lasted 7 cycles. B green then runs the full 10 cycles (`req_q` cleared).
- **Request before minimum:** `Solicitud` at `B_VERDE` `cnt = 0` → B green lasts exactly 4 cycles, then B=1 for 3.
- **Request during clearance:** `Solicitud` at `ROJO_BA` `cnt = 1` (the exit edge) → `req_q` stays set, and B green lasts 4 cycles.
